// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one fabric command becomes one full bus cycle
// (strobe, wait for ack, release, wait for ack to drop). Each bus phase has a
// bounded timeout. The response is registered and carries an error flag. The
// responder interrupt line is latched into a sticky pending flag.
module wb_cmd_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    wbm_clk_i,
  input  logic                    wbm_rst_n_i,
  // Fabric command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [DATA_WIDTH-1:0]   cmd_dat,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel,
  // Fabric response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic                    rsp_err,
  // Interrupt
  output logic                    irq_pending,
  input  logic                    irq_clr,
  // Wishbone initiator port
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_int_i
);

  localparam int unsigned SelW = DATA_WIDTH / 8;
  // Last count value of a bus phase; reaching it with no progress aborts the phase.
  localparam logic [15:0] TcntLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StRelease,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           tcnt_q, tcnt_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  irq_q, irq_d;
  logic                  tcnt_done;

  assign tcnt_done = (tcnt_q == TcntLast);

  // State register and all datapath registers; reset is immediate.
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n_i) begin
    if (!wbm_rst_n_i) begin
      state_q     <= StIdle;
      tcnt_q      <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      irq_q       <= irq_d;
    end
  end

  // Next-state and datapath updates for the command/bus/response sequence.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          tcnt_d  = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        if (wbm_ack_i) begin
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          cyc_d     = 1'b0;
          tcnt_d    = '0;
          state_d   = StRelease;
        end else if (tcnt_done) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          cyc_d     = 1'b0;
          tcnt_d    = '0;
          state_d   = StRelease;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      StRelease: begin
        // Responders may hold ack until they see stb fall; wait for it to drop.
        if (!wbm_ack_i) begin
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (tcnt_done) begin
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sticky interrupt flag; a set on the same edge as a clear wins.
  always_comb begin
    irq_d = irq_q;
    if (wbm_int_i) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_err     = rsp_err_q;
  assign irq_pending = irq_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;

endmodule
